// File: rtl/rx_frame_pkg.sv
// Shared frame layout constants and sequencer state encoding for the UART-style
// receive path. The frame is 11 bits, LSB first:
//   [0] start, [7:1] data, [8] even parity, [10:9] stop bits.
package rx_frame_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 7;
  localparam int START_POS  = 0;
  localparam int PARITY_POS = 8;
  localparam int IDX_W      = 4;

  localparam logic [1:0] STOP_PATTERN = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    CHECK,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/rx_frame_sequencer_parity.sv
// Combinational frame checker. It pulls the data field out of a captured frame
// and flags an even-parity mismatch or a bad start/stop pattern.
module ParityReciever
  import rx_frame_pkg::*;
(
  input  logic [FRAME_BITS-1:0] Data,
  output logic [DATA_BITS-1:0]  OutData,
  output logic                  ParityError,
  output logic                  FramingError
);

  assign OutData      = Data[START_POS+1 +: DATA_BITS];
  // Even parity: the parity bit must equal the XOR of the data bits.
  assign ParityError  = Data[PARITY_POS] ^ (^Data[START_POS+1 +: DATA_BITS]);
  // Start bit must be low and both stop bits high.
  assign FramingError = Data[START_POS] |
                        (Data[FRAME_BITS-1 -: 2] != STOP_PATTERN);

endmodule

// File: rtl/rx_frame_sequencer.sv
// Receive-side sequencer. It oversamples the serial line, validates the start
// bit at its mid-point, shifts in the rest of the frame one sample per bit
// period, runs the frame through the checker, and holds the result for a
// valid/ready consumer. If the consumer has not taken the previous character,
// the new frame is dropped and the overrun flag is raised.
module rx_frame_sequencer
  import rx_frame_pkg::*;
#(
  parameter int OVERSAMPLE = 16
)
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sample_tick,
  input  logic                 i_rx_in,
  input  logic                 i_rx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_framing_err,
  output logic                 o_overrun_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);

  // Tick counts are compared against count-minus-one because the counter
  // starts at zero on the edge that enters the state.
  localparam logic [CW-1:0]    HALF_M1  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0]    FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic [CW-1:0]         r_tick_cnt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [FRAME_BITS-1:0] r_frame;

  logic [DATA_BITS-1:0]  r_rx_data;
  logic                  r_rx_valid;
  logic                  r_parity_err;
  logic                  r_framing_err;
  logic                  r_overrun_err;

  logic                  w_start_det;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_sample;
  logic                  w_load_chk;

  logic [DATA_BITS-1:0]  w_chk_data;
  logic                  w_chk_pe;
  logic                  w_chk_fe;

  ParityReciever u_checker (
    .Data         (r_frame),
    .OutData      (w_chk_data),
    .ParityError  (w_chk_pe),
    .FramingError (w_chk_fe)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes; everything except CHECK waits for a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_start_det = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_sample    = 1'b0;
    w_load_chk  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_sample_tick && !i_rx_in) begin
          w_start_det = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (i_sample_tick) begin
          if (r_tick_cnt == HALF_M1) begin
            w_cnt_clr = 1'b1;
            // A line that is high again by mid-bit was a glitch, not a start.
            if (!i_rx_in) begin
              w_sample    = 1'b1;
              w_state_nxt = SHIFT;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (i_sample_tick) begin
          if (r_tick_cnt == FULL_M1) begin
            w_cnt_clr = 1'b1;
            w_sample  = 1'b1;
            if (r_bit_idx == LAST_IDX) w_state_nxt = CHECK;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      CHECK: begin
        w_load_chk  = 1'b1;
        // After a framing error the line may be held low (break); wait for
        // it to go high before arming start detection again.
        w_state_nxt = w_chk_fe ? WAIT_IDLE : IDLE;
      end
      WAIT_IDLE: begin
        if (i_sample_tick && i_rx_in) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Tick counter, bit index and frame shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_frame    <= '0;
    end else begin
      if (w_cnt_clr)      r_tick_cnt <= '0;
      else if (w_cnt_inc) r_tick_cnt <= r_tick_cnt + CW'(1);

      if (w_start_det) begin
        r_bit_idx <= '0;
      end else if (w_sample) begin
        r_frame[r_bit_idx] <= i_rx_in;
        // Saturate on the last bit so the index never leaves 0..10.
        if (r_bit_idx != LAST_IDX) r_bit_idx <= r_bit_idx + IDX_W'(1);
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else if (w_load_chk) begin
      // A same-cycle accept frees the slot, so the new frame can replace it.
      if (!r_rx_valid || i_rx_ready) begin
        r_rx_data     <= w_chk_data;
        r_parity_err  <= w_chk_pe;
        r_framing_err <= w_chk_fe;
        r_overrun_err <= 1'b0;
        r_rx_valid    <= 1'b1;
      end else begin
        r_overrun_err <= 1'b1;
      end
    end else if (r_rx_valid && i_rx_ready) begin
      r_rx_valid    <= 1'b0;
      r_overrun_err <= 1'b0;
    end
  end

  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_parity_err  = r_parity_err;
  assign o_framing_err = r_framing_err;
  assign o_overrun_err = r_overrun_err;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Bench for rx_frame_sequencer: directed scenarios followed by random frames,
// with expected characters and flags derived from how each frame was built.
module tb_rx_frame_sequencer;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       rx;
  logic       ready;
  logic [6:0] rx_data;
  logic       rx_valid;
  logic       pe;
  logic       fe;
  logic       ov;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vcnt     = 0;

  typedef struct {
    logic [6:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
    int         cyc;
  } obs_t;

  obs_t q[$];

  rx_frame_sequencer #(.OVERSAMPLE(OS)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sample_tick (tick),
    .i_rx_in       (rx),
    .i_rx_ready    (ready),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .o_parity_err  (pe),
    .o_framing_err (fe),
    .o_overrun_err (ov),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted character and count cycles with valid high.
  always @(negedge clk) begin
    #1;
    if (rx_valid) vcnt++;
    if (rx_valid && ready) q.push_back('{rx_data, pe, fe, ov, cyc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Build a frame: start 0, data LSB first, parity (optionally corrupted), stops.
  function automatic logic [10:0] mk_frame(input logic [6:0] d, input bit par_ok,
                                           input logic [1:0] stop);
    logic p;
    p = (^d) ^ ~par_ok;
    return {stop, p, d, 1'b0};
  endfunction

  // Drive the 11 bits, each held OS cycles; line left at the last bit value.
  task automatic send_frame(input logic [10:0] f, output int t0);
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (OS) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Expect exactly one captured character and compare it.
  task automatic check_pop(input string tag, input logic [6:0] d, input logic epe,
                           input logic efe, input logic eov, output int c);
    obs_t o;
    c = -1;
    check({tag, ".count"}, q.size(), 1);
    if (q.size() > 0) begin
      o = q.pop_front();
      c = o.cyc;
      check({tag, ".data"}, o.d, d);
      check({tag, ".pe"}, o.pe, epe);
      check({tag, ".fe"}, o.fe, efe);
      check({tag, ".ov"}, o.ov, eov);
    end
    q.delete();
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, ".data"}, rx_data, 0);
    check({tag, ".valid"}, rx_valid, 0);
    check({tag, ".pe"}, pe, 0);
    check({tag, ".fe"}, fe, 0);
    check({tag, ".ov"}, ov, 0);
    check({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    int t0;
    int c;
    int v0;
    logic [6:0] d;
    bit         pok;
    logic [1:0] st;
    logic [10:0] f;

    rst_n = 1'b0;
    tick  = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    rst_n = 1'b1;
    idle(5);

    // Good frame 0x55: exact latency and a single valid cycle.
    v0 = vcnt;
    send_frame(mk_frame(7'h55, 1'b1, 2'b11), t0);
    idle(4);
    check_pop("f55", 7'h55, 1'b0, 1'b0, 1'b0, c);
    check("f55.latency", c, t0 + 170);
    check("f55.vcycles", vcnt - v0, 1);
    check("f55.busy", busy, 0);

    // Bad parity.
    send_frame(mk_frame(7'h01, 1'b0, 2'b11), t0);
    idle(4);
    check_pop("f01", 7'h01, 1'b1, 1'b0, 1'b0, c);

    // Missing last stop bit, then the line stays low (break).
    v0 = vcnt;
    send_frame(mk_frame(7'h3C, 1'b1, 2'b01), t0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("brk.busy", busy, 1);
    check("brk.vcycles", vcnt - v0, 1);
    check_pop("f3c", 7'h3C, 1'b0, 1'b1, 1'b0, c);
    idle(3);
    check("brk.release", busy, 0);

    // False start: 4 cycles low.
    v0 = vcnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    check("glitch.busy_hi", busy, 1);
    repeat (2) @(negedge clk);
    idle(12);
    check("glitch.busy_lo", busy, 0);
    check("glitch.valid", vcnt - v0, 0);
    check("glitch.q", q.size(), 0);

    // Overrun: two frames with no consumer.
    ready = 1'b0;
    send_frame(mk_frame(7'h12, 1'b1, 2'b11), t0);
    idle(4);
    check("ovr.valid1", rx_valid, 1);
    check("ovr.data1", rx_data, 7'h12);
    check("ovr.ov1", ov, 0);
    send_frame(mk_frame(7'h34, 1'b1, 2'b11), t0);
    idle(4);
    check("ovr.valid2", rx_valid, 1);
    check("ovr.data2", rx_data, 7'h12);
    check("ovr.ov2", ov, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("ovr.acc_valid", rx_valid, 0);
    check("ovr.acc_ov", ov, 0);
    check("ovr.acc_data", rx_data, 7'h12);
    check_pop("ovr", 7'h12, 1'b0, 1'b0, 1'b1, c);

    // Reset in the middle of data bit 5 with a character held.
    send_frame(mk_frame(7'h2A, 1'b1, 2'b11), t0);
    idle(4);
    check("rst.held", rx_valid, 1);
    f = mk_frame(7'h33, 1'b1, 2'b11);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rx = f[i];
      repeat ((i == 5) ? OS/2 : OS) @(negedge clk);
    end
    check("rst.busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_outs_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    idle(5);
    check("rst.idle", busy, 0);
    send_frame(mk_frame(7'h7F, 1'b1, 2'b11), t0);
    idle(4);
    check_pop("f7f", 7'h7F, 1'b0, 1'b0, 1'b0, c);

    // Random frames: random data, occasional parity and stop corruption.
    for (int n = 0; n < 16; n++) begin
      d   = 7'($urandom);
      pok = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
      send_frame(mk_frame(d, pok, st), t0);
      idle($urandom_range(2, 20));
      check_pop("rand", d, ~pok, (st != 2'b11), 1'b0, c);
      check("rand.latency", c, t0 + 170);
      check("rand.busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard bound on run length.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
